// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Bubble encoding used when no entry is valid.
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared only by reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with valid/ready handshake, two-entry skid buffer,
// flush-to-bubble and a saturating stall-cycle counter.
module if_id_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned         INSTR_W   = 32,
    parameter int unsigned         PC_W      = 32,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(NOP_DEFAULT),
    parameter int unsigned         CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc4_i,
    input  logic               flush_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc4_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    pipe_state_e        state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc4_q, main_pc4_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc4_q, skid_pc4_d;

    logic acc_in;
    logic acc_out;

    // Both handshake flags decode straight from the state register, so
    // neither has a combinational path from any input.
    assign valid_o = (state_q != ST_EMPTY);
    assign ready_o = (state_q != ST_SKID);

    assign acc_in  = valid_i & ready_o & ~flush_i;
    assign acc_out = valid_o & ready_i;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc4_d   = main_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        case (state_q)
            ST_EMPTY: begin
                if (acc_in) begin
                    main_instr_d = instr_i;
                    main_pc4_d   = pc4_i;
                    state_d      = ST_FULL;
                end
            end
            ST_FULL: begin
                if (acc_in && acc_out) begin
                    main_instr_d = instr_i;
                    main_pc4_d   = pc4_i;
                end else if (acc_in) begin
                    skid_instr_d = instr_i;
                    skid_pc4_d   = pc4_i;
                    state_d      = ST_SKID;
                end else if (acc_out) begin
                    main_instr_d = NOP_INSTR;
                    main_pc4_d   = '0;
                    state_d      = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (acc_out) begin
                    main_instr_d = skid_instr_q;
                    main_pc4_d   = skid_pc4_q;
                    state_d      = ST_FULL;
                end
            end
            default: begin
                main_instr_d = NOP_INSTR;
                main_pc4_d   = '0;
                state_d      = ST_EMPTY;
            end
        endcase

        // A redirect overrides everything; a same-cycle consume still completes.
        if (flush_i) begin
            main_instr_d = NOP_INSTR;
            main_pc4_d   = '0;
            state_d      = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_INSTR;
            main_pc4_q   <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc4_q   <= main_pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign instr_o = main_instr_q;
    assign pc4_o   = main_pc4_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc   (valid_o & ~ready_i),
        .cnt   (stall_cnt_o)
    );

endmodule
